// File: rtl/forwarding_hazard_unit.sv
// forwarding_hazard_unit
// Operand-bypass select generation and load-use stall control for a classic
// five-stage in-order pipeline. The unit keeps its own copy of the destination
// information of the instructions in EX, MEM and WB. From that copy it decides
// which ALU operands must come from the bypass network, and whether the
// instruction in ID must wait one cycle behind a load.
module forwarding_hazard_unit #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pipe_en,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_count
);

  // Operand source selects as decoded by the ALU input muxes.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // Destination information carried by every stage slot.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
  } dst_slot_t;

  // The EX slot also keeps its sources, because the bypass selects are
  // computed for the instruction that currently sits in EX.
  typedef struct packed {
    dst_slot_t         dst;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              uses_rs1;
    logic              uses_rs2;
  } ex_slot_t;

  localparam dst_slot_t DST_EMPTY = '{
    valid:     1'b0,
    rd:        REG_ZERO,
    reg_write: 1'b0,
    mem_read:  1'b0
  };

  localparam ex_slot_t EX_EMPTY = '{
    dst:      DST_EMPTY,
    rs1:      REG_ZERO,
    rs2:      REG_ZERO,
    uses_rs1: 1'b0,
    uses_rs2: 1'b0
  };

  // A slot can act as a bypass source or a hazard source only when it really
  // writes a register other than x0. x0 is hard-wired to zero, so a write to
  // it is never observable.
  function automatic logic produces_reg(input dst_slot_t s);
    return s.valid && s.reg_write && (s.rd != REG_ZERO);
  endfunction

  // Bypass select for one EX operand. The youngest producer (MEM) wins over
  // WB. Nothing older than WB needs bypassing, because the register file
  // writes before it reads.
  function automatic logic [1:0] bypass_select(input dst_slot_t         mem_s,
                                               input dst_slot_t         wb_s,
                                               input logic [REG_AW-1:0] rs,
                                               input logic              uses);
    logic [1:0] sel;
    if (uses && produces_reg(mem_s) && (mem_s.rd == rs)) begin
      sel = FWD_MEM;
    end else if (uses && produces_reg(wb_s) && (wb_s.rd == rs)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

  ex_slot_t         ex_q;
  ex_slot_t         ex_d;
  dst_slot_t        mem_q;
  dst_slot_t        mem_d;
  dst_slot_t        wb_q;
  dst_slot_t        wb_d;
  logic [CNT_W-1:0] stall_count_q;
  logic [CNT_W-1:0] stall_count_d;

  ex_slot_t         id_slot_s;
  logic             load_in_ex_s;
  logic             rs_hits_load_s;
  logic             stall_s;
  logic [1:0]       fwd_a_s;
  logic [1:0]       fwd_b_s;

  // WB keeps its load flag so that the slot layout stays uniform. Nothing
  // downstream of WB consumes the flag.
  logic             unused_wb_mem_read_s;
  assign unused_wb_mem_read_s = wb_q.mem_read;

  // Package the decode-stage fields into the form the EX slot stores.
  always_comb begin
    id_slot_s.dst.valid     = 1'b1;
    id_slot_s.dst.rd        = id_rd;
    id_slot_s.dst.reg_write = id_reg_write;
    id_slot_s.dst.mem_read  = id_mem_read;
    id_slot_s.rs1           = id_rs1;
    id_slot_s.rs2           = id_rs2;
    id_slot_s.uses_rs1      = id_uses_rs1;
    id_slot_s.uses_rs2      = id_uses_rs2;
  end

  // Load-use detection: a load in EX whose result ID needs next cycle. The
  // data arrives one stage too late to bypass, so ID waits one cycle. A flush
  // kills the ID instruction, so there is nothing left to protect and the
  // flush overrides the stall.
  always_comb begin
    load_in_ex_s   = produces_reg(ex_q.dst) && ex_q.dst.mem_read;
    rs_hits_load_s = (id_uses_rs1 && (id_rs1 == ex_q.dst.rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_q.dst.rd));
    if (id_valid && !flush && load_in_ex_s && rs_hits_load_s) begin
      stall_s = 1'b1;
    end else begin
      stall_s = 1'b0;
    end
  end

  // Bypass selects for the EX instruction. An empty EX slot has no operands,
  // so both selects park on the register file.
  always_comb begin
    if (ex_q.dst.valid) begin
      fwd_a_s = bypass_select(mem_q, wb_q, ex_q.rs1, ex_q.uses_rs1);
      fwd_b_s = bypass_select(mem_q, wb_q, ex_q.rs2, ex_q.uses_rs2);
    end else begin
      fwd_a_s = FWD_RF;
      fwd_b_s = FWD_RF;
    end
  end

  // Next-state logic: shift the slots one stage per enabled cycle, and insert
  // a bubble into EX on a stall, a flush or an empty ID.
  always_comb begin
    ex_d          = ex_q;
    mem_d         = mem_q;
    wb_d          = wb_q;
    stall_count_d = stall_count_q;
    if (pipe_en) begin
      wb_d  = mem_q;
      mem_d = ex_q.dst;
      if (stall_s || flush || !id_valid) begin
        ex_d = EX_EMPTY;
      end else begin
        ex_d = id_slot_s;
      end
      // The counter wraps to zero naturally after its all-ones value.
      if (stall_s) begin
        stall_count_d = stall_count_q + CNT_ONE;
      end else begin
        stall_count_d = stall_count_q;
      end
    end else begin
      ex_d          = ex_q;
      mem_d         = mem_q;
      wb_d          = wb_q;
      stall_count_d = stall_count_q;
    end
  end

  // Stage slots and stall counter. The asynchronous reset empties every slot,
  // so the stall and bypass outputs drop without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q          <= EX_EMPTY;
      mem_q         <= DST_EMPTY;
      wb_q          <= DST_EMPTY;
      stall_count_q <= CNT_ZERO;
    end else begin
      ex_q          <= ex_d;
      mem_q         <= mem_d;
      wb_q          <= wb_d;
      stall_count_q <= stall_count_d;
    end
  end

  // Selects and stall feed the same-cycle datapath muxes and front-end
  // enables, so they are decoded straight from the slot state.
  assign forward_a   = fwd_a_s;
  assign forward_b   = fwd_b_s;
  assign stall       = stall_s;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Self-checking bench for forwarding_hazard_unit. Each scenario queues its
// stimulus and the expected bypass/stall outputs for every cycle, then
// replays the queue and compares the DUT outputs against the expectations.
// A second instance with a 2-bit counter exercises the counter wrap.
module tb_forwarding_hazard_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pipe_en;
  logic       flush;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_uses_rs1;
  logic       id_uses_rs2;
  logic [4:0] id_rd;
  logic       id_reg_write;
  logic       id_mem_read;

  logic [1:0]  forward_a;
  logic [1:0]  forward_b;
  logic        stall;
  logic [31:0] stall_count;
  logic [1:0]  forward_a_sm;
  logic [1:0]  forward_b_sm;
  logic        stall_sm;
  logic [1:0]  stall_count_sm;

  typedef struct {
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic       fl;
    logic       pen;
    logic       rst_mid;
  } stim_t;

  typedef struct {
    logic [1:0] fa;
    logic [1:0] fb;
    logic       st;
    string      tag;
  } exp_t;

  stim_t       stim_q[$];
  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_cnt = 32'd0;

  always #5 clk = ~clk;

  forwarding_hazard_unit #(.REG_AW(5), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .pipe_en(pipe_en), .flush(flush),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .forward_a(forward_a), .forward_b(forward_b), .stall(stall),
    .stall_count(stall_count)
  );

  forwarding_hazard_unit #(.REG_AW(5), .CNT_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .pipe_en(pipe_en), .flush(flush),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .forward_a(forward_a_sm), .forward_b(forward_b_sm), .stall(stall_sm),
    .stall_count(stall_count_sm)
  );

  function automatic stim_t nop();
    stim_t s;
    s.valid = 1'b0; s.rs1 = 5'd0; s.rs2 = 5'd0; s.u1 = 1'b0; s.u2 = 1'b0;
    s.rd = 5'd0; s.rw = 1'b0; s.mr = 1'b0; s.fl = 1'b0; s.pen = 1'b1;
    s.rst_mid = 1'b0;
    return s;
  endfunction

  function automatic stim_t alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    stim_t s;
    s = nop();
    s.valid = 1'b1; s.rs1 = rs1; s.rs2 = rs2; s.u1 = 1'b1; s.u2 = 1'b1;
    s.rd = rd; s.rw = 1'b1;
    return s;
  endfunction

  function automatic stim_t ld(input logic [4:0] rd, input logic [4:0] rs1);
    stim_t s;
    s = nop();
    s.valid = 1'b1; s.rs1 = rs1; s.u1 = 1'b1; s.rd = rd; s.rw = 1'b1; s.mr = 1'b1;
    return s;
  endfunction

  task automatic push(input stim_t s, input logic [1:0] fa, input logic [1:0] fb,
                      input logic st, input string tag);
    exp_t e;
    e.fa = fa; e.fb = fb; e.st = st; e.tag = tag;
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic apply(input stim_t s);
    id_valid = s.valid; id_rs1 = s.rs1; id_rs2 = s.rs2;
    id_uses_rs1 = s.u1; id_uses_rs2 = s.u2; id_rd = s.rd;
    id_reg_write = s.rw; id_mem_read = s.mr; flush = s.fl; pipe_en = s.pen;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    apply(nop());
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_cnt = 32'd0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    apply(ld(5'd8, 5'd2));
    @(posedge clk); #1;
    apply(alu(5'd9, 5'd8, 5'd8));
    @(posedge clk); #2;
    checks++; if (forward_a !== 2'b00) begin errors++; $display("FAIL reset forward_a: got %b expected 00", forward_a); end
    checks++; if (forward_b !== 2'b00) begin errors++; $display("FAIL reset forward_b: got %b expected 00", forward_b); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset stall: got %b expected 0", stall); end
    checks++; if (stall_count !== 32'd0) begin errors++; $display("FAIL reset stall_count: got %0d expected 0", stall_count); end
    checks++; if (stall_count_sm !== 2'd0) begin errors++; $display("FAIL reset small stall_count: got %0d expected 0", stall_count_sm); end
  endtask

  task automatic test_back_to_back();
    stim_t s; exp_t e;
    do_reset();
    push(alu(5'd5, 5'd1, 5'd2), 2'b00, 2'b00, 1'b0, "b2b add in ID");
    push(alu(5'd6, 5'd5, 5'd3), 2'b00, 2'b00, 1'b0, "b2b sub in ID");
    push(nop(),                 2'b10, 2'b00, 1'b0, "b2b sub in EX");
    push(nop(),                 2'b00, 2'b00, 1'b0, "b2b drain");
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      apply(s); #2;
      checks++; if (forward_a !== e.fa) begin errors++; $display("FAIL %s forward_a: got %b expected %b", e.tag, forward_a, e.fa); end
      checks++; if (forward_b !== e.fb) begin errors++; $display("FAIL %s forward_b: got %b expected %b", e.tag, forward_b, e.fb); end
      checks++; if (stall !== e.st) begin errors++; $display("FAIL %s stall: got %b expected %b", e.tag, stall, e.st); end
      checks++; if (stall_count !== model_cnt) begin errors++; $display("FAIL %s stall_count: got %0d expected %0d", e.tag, stall_count, model_cnt); end
      if (e.st && s.pen) model_cnt = model_cnt + 32'd1;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_two_apart();
    stim_t s; exp_t e;
    do_reset();
    push(alu(5'd5, 5'd1, 5'd2), 2'b00, 2'b00, 1'b0, "2apart add");
    push(nop(),                 2'b00, 2'b00, 1'b0, "2apart nop");
    push(alu(5'd7, 5'd4, 5'd5), 2'b00, 2'b00, 1'b0, "2apart and in ID");
    push(nop(),                 2'b00, 2'b01, 1'b0, "2apart and in EX");
    push(alu(5'd5, 5'd1, 5'd2), 2'b00, 2'b00, 1'b0, "prio first add");
    push(alu(5'd5, 5'd1, 5'd3), 2'b00, 2'b00, 1'b0, "prio second add");
    push(alu(5'd7, 5'd4, 5'd5), 2'b00, 2'b00, 1'b0, "prio and in ID");
    push(nop(),                 2'b00, 2'b10, 1'b0, "prio MEM over WB");
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      apply(s); #2;
      checks++; if (forward_a !== e.fa) begin errors++; $display("FAIL %s forward_a: got %b expected %b", e.tag, forward_a, e.fa); end
      checks++; if (forward_b !== e.fb) begin errors++; $display("FAIL %s forward_b: got %b expected %b", e.tag, forward_b, e.fb); end
      checks++; if (stall !== e.st) begin errors++; $display("FAIL %s stall: got %b expected %b", e.tag, stall, e.st); end
      checks++; if (stall_count !== model_cnt) begin errors++; $display("FAIL %s stall_count: got %0d expected %0d", e.tag, stall_count, model_cnt); end
      if (e.st && s.pen) model_cnt = model_cnt + 32'd1;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    stim_t s; exp_t e;
    do_reset();
    push(ld(5'd8, 5'd2),        2'b00, 2'b00, 1'b0, "lu load in ID");
    push(alu(5'd9, 5'd8, 5'd8), 2'b00, 2'b00, 1'b1, "lu stall");
    push(alu(5'd9, 5'd8, 5'd8), 2'b00, 2'b00, 1'b0, "lu bubble in EX");
    push(nop(),                 2'b01, 2'b01, 1'b0, "lu forward from WB");
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      apply(s); #2;
      checks++; if (forward_a !== e.fa) begin errors++; $display("FAIL %s forward_a: got %b expected %b", e.tag, forward_a, e.fa); end
      checks++; if (forward_b !== e.fb) begin errors++; $display("FAIL %s forward_b: got %b expected %b", e.tag, forward_b, e.fb); end
      checks++; if (stall !== e.st) begin errors++; $display("FAIL %s stall: got %b expected %b", e.tag, stall, e.st); end
      checks++; if (stall_count !== model_cnt) begin errors++; $display("FAIL %s stall_count: got %0d expected %0d", e.tag, stall_count, model_cnt); end
      if (e.st && s.pen) model_cnt = model_cnt + 32'd1;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_x0();
    stim_t s; exp_t e;
    do_reset();
    push(alu(5'd0, 5'd1, 5'd2), 2'b00, 2'b00, 1'b0, "x0 add to x0");
    push(alu(5'd3, 5'd0, 5'd0), 2'b00, 2'b00, 1'b0, "x0 reader in ID");
    push(nop(),                 2'b00, 2'b00, 1'b0, "x0 no forward");
    push(ld(5'd0, 5'd1),        2'b00, 2'b00, 1'b0, "x0 load in ID");
    push(alu(5'd3, 5'd0, 5'd0), 2'b00, 2'b00, 1'b0, "x0 load no stall");
    push(nop(),                 2'b00, 2'b00, 1'b0, "x0 load no forward");
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      apply(s); #2;
      checks++; if (forward_a !== e.fa) begin errors++; $display("FAIL %s forward_a: got %b expected %b", e.tag, forward_a, e.fa); end
      checks++; if (forward_b !== e.fb) begin errors++; $display("FAIL %s forward_b: got %b expected %b", e.tag, forward_b, e.fb); end
      checks++; if (stall !== e.st) begin errors++; $display("FAIL %s stall: got %b expected %b", e.tag, stall, e.st); end
      checks++; if (stall_count !== model_cnt) begin errors++; $display("FAIL %s stall_count: got %0d expected %0d", e.tag, stall_count, model_cnt); end
      if (e.st && s.pen) model_cnt = model_cnt + 32'd1;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush();
    stim_t s; exp_t e; stim_t f;
    do_reset();
    f = alu(5'd9, 5'd8, 5'd8);
    f.fl = 1'b1;
    push(ld(5'd8, 5'd2), 2'b00, 2'b00, 1'b0, "flush load in ID");
    push(f,              2'b00, 2'b00, 1'b0, "flush kills stall");
    push(nop(),          2'b00, 2'b00, 1'b0, "flush bubble in EX");
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      apply(s); #2;
      checks++; if (forward_a !== e.fa) begin errors++; $display("FAIL %s forward_a: got %b expected %b", e.tag, forward_a, e.fa); end
      checks++; if (forward_b !== e.fb) begin errors++; $display("FAIL %s forward_b: got %b expected %b", e.tag, forward_b, e.fb); end
      checks++; if (stall !== e.st) begin errors++; $display("FAIL %s stall: got %b expected %b", e.tag, stall, e.st); end
      checks++; if (stall_count !== model_cnt) begin errors++; $display("FAIL %s stall_count: got %0d expected %0d", e.tag, stall_count, model_cnt); end
      if (e.st && s.pen) model_cnt = model_cnt + 32'd1;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_freeze_and_reset();
    stim_t s; exp_t e; stim_t hz; stim_t frz; stim_t rs;
    do_reset();
    hz  = alu(5'd9, 5'd8, 5'd8);
    frz = hz;
    frz.pen = 1'b0;
    rs = alu(5'd10, 5'd8, 5'd8);
    rs.rst_mid = 1'b1;
    push(ld(5'd8, 5'd2),        2'b00, 2'b00, 1'b0, "frz load in ID");
    push(frz,                   2'b00, 2'b00, 1'b1, "frz hold 1");
    push(frz,                   2'b00, 2'b00, 1'b1, "frz hold 2");
    push(frz,                   2'b00, 2'b00, 1'b1, "frz hold 3");
    push(hz,                    2'b00, 2'b00, 1'b1, "frz release");
    push(hz,                    2'b00, 2'b00, 1'b0, "frz bubble");
    push(nop(),                 2'b01, 2'b01, 1'b0, "frz forward");
    push(alu(5'd9, 5'd1, 5'd2), 2'b00, 2'b00, 1'b0, "rst add x9");
    push(ld(5'd8, 5'd9),        2'b00, 2'b00, 1'b0, "rst load in ID");
    push(rs,                    2'b10, 2'b00, 1'b1, "rst stall before reset");
    push(alu(5'd5, 5'd1, 5'd2), 2'b00, 2'b00, 1'b0, "rst add after reset");
    push(alu(5'd6, 5'd5, 5'd3), 2'b00, 2'b00, 1'b0, "rst sub in ID");
    push(nop(),                 2'b10, 2'b00, 1'b0, "rst issue resumes");
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      apply(s); #2;
      checks++; if (forward_a !== e.fa) begin errors++; $display("FAIL %s forward_a: got %b expected %b", e.tag, forward_a, e.fa); end
      checks++; if (forward_b !== e.fb) begin errors++; $display("FAIL %s forward_b: got %b expected %b", e.tag, forward_b, e.fb); end
      checks++; if (stall !== e.st) begin errors++; $display("FAIL %s stall: got %b expected %b", e.tag, stall, e.st); end
      checks++; if (stall_count !== model_cnt) begin errors++; $display("FAIL %s stall_count: got %0d expected %0d", e.tag, stall_count, model_cnt); end
      if (e.st && s.pen) model_cnt = model_cnt + 32'd1;
      if (s.rst_mid) begin
        rst_n = 1'b0;
        model_cnt = 32'd0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL async reset stall: got %b expected 0", stall); end
        checks++; if (forward_a !== 2'b00) begin errors++; $display("FAIL async reset forward_a: got %b expected 00", forward_a); end
        checks++; if (forward_b !== 2'b00) begin errors++; $display("FAIL async reset forward_b: got %b expected 00", forward_b); end
        checks++; if (stall_count !== 32'd0) begin errors++; $display("FAIL async reset stall_count: got %0d expected 0", stall_count); end
        @(negedge clk);
        rst_n = 1'b1;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_wrap();
    stim_t s; exp_t e; logic [1:0] small_exp;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      push(ld(5'd8, 5'd2),        2'b00, 2'b00, 1'b0, "wrap load");
      push(alu(5'd9, 5'd8, 5'd8), 2'b00, 2'b00, 1'b1, "wrap stall");
      push(alu(5'd9, 5'd8, 5'd8), 2'b00, 2'b00, 1'b0, "wrap bubble");
      push(nop(),                 2'b01, 2'b01, 1'b0, "wrap forward");
    end
    push(nop(), 2'b00, 2'b00, 1'b0, "wrap final");
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      apply(s); #2;
      small_exp = model_cnt[1:0];
      checks++; if (stall !== e.st) begin errors++; $display("FAIL %s stall: got %b expected %b", e.tag, stall, e.st); end
      checks++; if (stall_count !== model_cnt) begin errors++; $display("FAIL %s stall_count: got %0d expected %0d", e.tag, stall_count, model_cnt); end
      checks++; if (forward_a_sm !== e.fa) begin errors++; $display("FAIL %s small forward_a: got %b expected %b", e.tag, forward_a_sm, e.fa); end
      checks++; if (forward_b_sm !== e.fb) begin errors++; $display("FAIL %s small forward_b: got %b expected %b", e.tag, forward_b_sm, e.fb); end
      checks++; if (stall_sm !== e.st) begin errors++; $display("FAIL %s small stall: got %b expected %b", e.tag, stall_sm, e.st); end
      checks++; if (stall_count_sm !== small_exp) begin errors++; $display("FAIL %s small stall_count: got %0d expected %0d", e.tag, stall_count_sm, small_exp); end
      if (e.st && s.pen) model_cnt = model_cnt + 32'd1;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    apply(nop());
    test_reset();
    test_back_to_back();
    test_two_apart();
    test_load_use();
    test_x0();
    test_flush();
    test_freeze_and_reset();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
